// File: rtl/mcsr_trap_pkg.sv
// Shared constants for the machine-mode CSR file: CSR addresses, bit positions
// inside mstatus/mie/mip/misa/mcause, and the mtvec mode encoding.
package mcsr_trap_pkg;

  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MARCHID   = 12'hF12;
  localparam logic [11:0] CSR_MIMPID    = 12'hF13;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;
  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;
  localparam int MSTATUS_MPP_LSB  = 11;

  localparam int IRQ_SW_BIT    = 3;
  localparam int IRQ_TIMER_BIT = 7;
  localparam int IRQ_EXT_BIT   = 11;

  localparam int         MISA_I_BIT  = 8;
  localparam logic [1:0] MISA_MXL_32 = 2'b01;

  localparam int MCAUSE_IRQ_BIT = 31;

  typedef enum logic [1:0] {
    MTVEC_DIRECT   = 2'd0,
    MTVEC_VECTORED = 2'd1
  } mtvec_mode_e;

  // Identification registers: readable, but a write is an illegal instruction.
  function automatic logic is_read_only(input logic [11:0] addr);
    return (addr == CSR_MVENDORID) || (addr == CSR_MARCHID) ||
           (addr == CSR_MIMPID)    || (addr == CSR_MHARTID);
  endfunction

endpackage

// File: rtl/mcsr_trap_counter64.sv
// Double-width performance counter with separate half-word write ports.
// A write to either half suppresses the increment for that cycle.
module csr_counter64 #(
  parameter int HALF_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inc,
  input  logic                wr_lo,
  input  logic                wr_hi,
  input  logic [HALF_W-1:0]   wdata,
  output logic [2*HALF_W-1:0] count
);

  logic [2*HALF_W-1:0] count_q, count_d;

  always_comb begin
    // NOTE: default every comb output first so no path leaves it unassigned (no latch).
    count_d = count_q;
    if (wr_lo || wr_hi) begin
      if (wr_lo) count_d[HALF_W-1:0]        = wdata;
      if (wr_hi) count_d[2*HALF_W-1:HALF_W] = wdata;
    end else if (inc) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking so every flop samples pre-edge values regardless of block order.
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/mcsr_trap.sv
// Machine-mode CSR file with trap entry/MRET sequencing, interrupt pending
// logic, direct/vectored trap vector and mcycle/minstret counters.
module mcsr_trap
  import mcsr_trap_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_MTVEC = '0,
  parameter int                    VECTORED_EN = 1,
  parameter int                    COUNTER_EN  = 1,
  parameter logic [DATA_WIDTH-1:0] HART_ID     = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  csr_rd,
  input  logic                  csr_wr,
  input  logic [11:0]           csr_addr,
  input  logic [DATA_WIDTH-1:0] csr_wdata,
  output logic [DATA_WIDTH-1:0] csr_rdata,
  output logic                  csr_illegal,
  input  logic                  take_trap,
  input  logic [DATA_WIDTH-1:0] trap_cause,
  input  logic [DATA_WIDTH-1:0] trap_val,
  input  logic [DATA_WIDTH-1:0] trap_pc,
  input  logic                  mret,
  input  logic                  instr_retire,
  input  logic                  ext_irq,
  input  logic                  timer_irq,
  input  logic                  sw_irq,
  output logic                  irq_pending,
  output logic [DATA_WIDTH-1:0] trap_vector,
  output logic [DATA_WIDTH-1:0] mepc_out,
  output logic [DATA_WIDTH-3:0] mtvec_base,
  output logic [1:0]            mtvec_mode
);

  localparam int DW = DATA_WIDTH;

  logic          mstatus_mie_q, mstatus_mie_d;
  logic          mstatus_mpie_q, mstatus_mpie_d;
  logic [DW-1:0] mie_q, mie_d;
  logic [DW-1:0] mscratch_q, mscratch_d;
  logic [DW-1:0] mepc_q, mepc_d;
  logic [DW-1:0] mcause_q, mcause_d;
  logic [DW-1:0] mtval_q, mtval_d;
  logic [DW-1:0] mtvec_q, mtvec_d;

  logic [2*DW-1:0] mcycle, minstret;
  logic [DW-1:0]   mstatus_rd, mip_rd, misa_rd, mie_mask;
  logic            addr_valid, wr_en;
  logic [1:0]      wr_mode;

  always_comb begin
    mstatus_rd = '0;
    mstatus_rd[MSTATUS_MPP_LSB+:2] = 2'b11;
    mstatus_rd[MSTATUS_MPIE_BIT]   = mstatus_mpie_q;
    mstatus_rd[MSTATUS_MIE_BIT]    = mstatus_mie_q;
    mip_rd = '0;
    mip_rd[IRQ_EXT_BIT]   = ext_irq;
    mip_rd[IRQ_TIMER_BIT] = timer_irq;
    mip_rd[IRQ_SW_BIT]    = sw_irq;
    mie_mask = '0;
    mie_mask[IRQ_EXT_BIT]   = 1'b1;
    mie_mask[IRQ_TIMER_BIT] = 1'b1;
    mie_mask[IRQ_SW_BIT]    = 1'b1;
    misa_rd = '0;
    misa_rd[DW-1:DW-2] = MISA_MXL_32;
    misa_rd[MISA_I_BIT] = 1'b1;
  end

  always_comb begin
    csr_rdata  = '0;
    addr_valid = 1'b1;
    case (csr_addr)
      CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID: csr_rdata = '0;
      CSR_MHARTID:   csr_rdata = HART_ID;
      CSR_MISA:      csr_rdata = misa_rd;
      CSR_MSTATUS:   csr_rdata = mstatus_rd;
      CSR_MIE:       csr_rdata = mie_q;
      CSR_MTVEC:     csr_rdata = mtvec_q;
      CSR_MSCRATCH:  csr_rdata = mscratch_q;
      CSR_MEPC:      csr_rdata = mepc_q;
      CSR_MCAUSE:    csr_rdata = mcause_q;
      CSR_MTVAL:     csr_rdata = mtval_q;
      CSR_MIP:       csr_rdata = mip_rd;
      CSR_MCYCLE:    csr_rdata = mcycle[DW-1:0];
      CSR_MCYCLEH:   csr_rdata = mcycle[2*DW-1:DW];
      CSR_MINSTRET:  csr_rdata = minstret[DW-1:0];
      CSR_MINSTRETH: csr_rdata = minstret[2*DW-1:DW];
      default:       addr_valid = 1'b0;
    endcase
  end

  assign csr_illegal = ((csr_rd || csr_wr) && !addr_valid) ||
                       (csr_wr && is_read_only(csr_addr));
  assign wr_en = csr_wr && !csr_illegal;

  // Later assignments override earlier ones: trap > mret > CSR write.
  always_comb begin
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    mie_d          = mie_q;
    mscratch_d     = mscratch_q;
    mepc_d         = mepc_q;
    mcause_d       = mcause_q;
    mtval_d        = mtval_q;
    mtvec_d        = mtvec_q;
    wr_mode        = csr_wdata[1:0];
    if ((VECTORED_EN == 0) || wr_mode[1]) wr_mode = MTVEC_DIRECT;

    if (wr_en) begin
      case (csr_addr)
        CSR_MSTATUS: begin
          mstatus_mie_d  = csr_wdata[MSTATUS_MIE_BIT];
          mstatus_mpie_d = csr_wdata[MSTATUS_MPIE_BIT];
        end
        CSR_MIE:      mie_d      = csr_wdata & mie_mask;
        CSR_MTVEC:    mtvec_d    = {csr_wdata[DW-1:2], wr_mode};
        CSR_MSCRATCH: mscratch_d = csr_wdata;
        CSR_MEPC:     mepc_d     = {csr_wdata[DW-1:2], 2'b00};
        CSR_MCAUSE:   mcause_d   = csr_wdata;
        CSR_MTVAL:    mtval_d    = csr_wdata;
        default: ;
      endcase
    end

    if (mret) begin
      mstatus_mie_d  = mstatus_mpie_q;
      mstatus_mpie_d = 1'b1;
    end

    if (take_trap) begin
      mepc_d         = {trap_pc[DW-1:2], 2'b00};
      mcause_d       = trap_cause;
      mtval_d        = trap_val;
      mstatus_mpie_d = mstatus_mie_q;
      mstatus_mie_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_q          <= '0;
      mscratch_q     <= '0;
      mepc_q         <= '0;
      mcause_q       <= '0;
      mtval_q        <= '0;
      mtvec_q        <= RESET_MTVEC;
    end else begin
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      mie_q          <= mie_d;
      mscratch_q     <= mscratch_d;
      mepc_q         <= mepc_d;
      mcause_q       <= mcause_d;
      mtval_q        <= mtval_d;
      mtvec_q        <= mtvec_d;
    end
  end

  always_comb begin
    trap_vector = {mtvec_q[DW-1:2], 2'b00};
    if ((VECTORED_EN != 0) && (mtvec_q[1:0] == MTVEC_VECTORED) && trap_cause[MCAUSE_IRQ_BIT])
      trap_vector = {mtvec_q[DW-1:2], 2'b00} + {trap_cause[DW-3:0], 2'b00};
  end

  assign irq_pending = mstatus_mie_q && |(mie_q & mip_rd);
  assign mepc_out    = mepc_q;
  assign mtvec_base  = mtvec_q[DW-1:2];
  assign mtvec_mode  = mtvec_q[1:0];

  if (COUNTER_EN != 0) begin : g_counters
    csr_counter64 #(.HALF_W(DW)) u_mcycle (
      .clk   (clk),
      .rst   (rst),
      .inc   (1'b1),
      .wr_lo (wr_en && (csr_addr == CSR_MCYCLE)),
      .wr_hi (wr_en && (csr_addr == CSR_MCYCLEH)),
      .wdata (csr_wdata),
      .count (mcycle)
    );
    csr_counter64 #(.HALF_W(DW)) u_minstret (
      .clk   (clk),
      .rst   (rst),
      .inc   (instr_retire),
      .wr_lo (wr_en && (csr_addr == CSR_MINSTRET)),
      .wr_hi (wr_en && (csr_addr == CSR_MINSTRETH)),
      .wdata (csr_wdata),
      .count (minstret)
    );
  end else begin : g_no_counters
    assign mcycle   = '0;
    assign minstret = '0;
  end

endmodule
